axis_text_framer: RTL and testbench

AXIS_TEXT_FRAMER -- requirements
Module: axis_text_framer

---
 rtl/axis_text_framer.sv | 86 ++++++++
 tb/tb_axis_text_framer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/axis_text_framer.sv
// axis_text_framer: packs an ASCII byte stream into a 4x16 character frame and emits it on a wide AXI-Stream output.
// Optional idle auto-flush when AXIS_TEXT_FRAMER_AUTO_FLUSH_EN is defined.
module axis_text_framer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [127:0] m_axis_tdata_str1,
  output logic [127:0] m_axis_tdata_str2,
  output logic [127:0] m_axis_tdata_str3,
  output logic [127:0] m_axis_tdata_str4,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready
);
  typedef enum logic {FILL, SEND} state_t;
  state_t       state;
  logic [511:0] cells;
  logic [5:0]   cur;
  logic         dirty;
  logic         acc;
  logic         prn;
  logic         is_lf;
  logic         is_cr;
  logic         is_ff;
  logic         timeout;
  logic         go_send;
  assign acc   = s_axis_tvalid & s_axis_tready;
  assign prn   = s_axis_tdata >= 8'h20 && s_axis_tdata <= 8'h7e;
  assign is_lf = s_axis_tdata == 8'h0a;
  assign is_cr = s_axis_tdata == 8'h0d;
  assign is_ff = s_axis_tdata == 8'h0c;
  assign {m_axis_tdata_str1, m_axis_tdata_str2, m_axis_tdata_str3, m_axis_tdata_str4} = cells;
`ifdef AXIS_TEXT_FRAMER_AUTO_FLUSH_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle;
  // Saturates so a clean buffer can idle forever without wrapping.
  always_ff @(posedge clk) begin
    if (!resetn || state == SEND || acc) idle <= '0;
    else if (idle != CW'(TIMEOUT_CYCLES - 1)) idle <= idle + CW'(1);
  end
  assign timeout = state == FILL && !acc && dirty && idle == CW'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  assign go_send = (acc && (is_ff || (prn && cur == 6'd63) || (is_lf && cur[5:4] == 2'd3))) || timeout;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= FILL;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      cells         <= {64{FILL_CHAR}};
      cur           <= '0;
      dirty         <= 1'b0;
    end else if (state == SEND) begin
      if (m_axis_tready) begin
        state         <= FILL;
        s_axis_tready <= 1'b1;
        m_axis_tvalid <= 1'b0;
        cells         <= {64{FILL_CHAR}};
        cur           <= '0;
        dirty         <= 1'b0;
      end
    end else begin
      s_axis_tready <= !go_send;
      if (go_send) begin
        state         <= SEND;
        m_axis_tvalid <= 1'b1;
      end
      // Cell index = line*16 + column, first cell in the top byte of the buffer.
      if (acc && prn) begin
        cells[511 - 8*int'(cur) -: 8] <= s_axis_tdata;
        cur   <= cur + 6'd1;
        dirty <= 1'b1;
      end else if (acc && is_lf) begin
        cur <= {cur[5:4] + 2'd1, 4'd0};
      end else if (acc && is_cr) begin
        cur[3:0] <= 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_axis_text_framer.sv
// tb_axis_text_framer: directed, table-driven checks of axis_text_framer frames, backpressure, reset and auto-flush.
module tb_axis_text_framer;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [7:0]   s_axis_tdata = 8'h00;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [127:0] m_axis_tdata_str1, m_axis_tdata_str2, m_axis_tdata_str3, m_axis_tdata_str4;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  int checks = 0;
  int errors = 0;
  localparam logic [511:0] BLANK = {64{8'h20}};

  axis_text_framer #(.TIMEOUT_CYCLES(16), .FILL_CHAR(8'h20)) dut (
    .clk(clk),
    .resetn(resetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata_str1(m_axis_tdata_str1),
    .m_axis_tdata_str2(m_axis_tdata_str2),
    .m_axis_tdata_str3(m_axis_tdata_str3),
    .m_axis_tdata_str4(m_axis_tdata_str4),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string txt;
    string l1, l2, l3, l4;
  } vec_t;

  function automatic logic [127:0] pad16(string s);
    logic [127:0] r = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) r[127 - 8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [511:0] frame();
    return {m_axis_tdata_str1, m_axis_tdata_str2, m_axis_tdata_str3, m_axis_tdata_str4};
  endfunction

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!s_axis_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 512'(s_axis_tready), 512'(1));
    check("no_early_frame", 512'(m_axis_tvalid), 512'(0));
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic expect_frame(string name, logic [511:0] exp);
    @(negedge clk);
    check({name, "_valid"}, 512'(m_axis_tvalid), 512'(1));
    check({name, "_data"}, frame(), exp);
    check({name, "_sready_low"}, 512'(s_axis_tready), 512'(0));
    @(negedge clk);
    check({name, "_valid_drop"}, 512'(m_axis_tvalid), 512'(0));
    check({name, "_cleared"}, frame(), BLANK);
    check({name, "_sready_back"}, 512'(s_axis_tready), 512'(1));
  endtask

  initial begin
    vec_t vecs[6];
    logic [511:0] held;
    int bad;
    vecs[0] = '{"HELLO\014", "HELLO", "", "", ""};
    vecs[1] = '{"A\nB\nC\nD\n", "A", "B", "C", "D"};
    vecs[2] = '{"ab\015XY\014", "XY", "", "", ""};
    vecs[3] = '{"\001Q\177\377R\014", "QR", "", "", ""};
    vecs[4] = '{"0123456789abcdefZ\014", "0123456789abcdef", "Z", "", ""};
    vecs[5] = '{"ab\ncd\015X\014", "ab", "Xd", "", ""};

    repeat (2) @(negedge clk);
    check("rst_valid", 512'(m_axis_tvalid), 512'(0));
    check("rst_sready", 512'(s_axis_tready), 512'(0));
    check("rst_cells", frame(), BLANK);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_release_sready", 512'(s_axis_tready), 512'(1));

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].txt.len(); i++) send_byte(vecs[v].txt[i]);
      expect_frame($sformatf("vec%0d", v),
        {pad16(vecs[v].l1), pad16(vecs[v].l2), pad16(vecs[v].l3), pad16(vecs[v].l4)});
    end

    // 64 printable bytes fill the frame; the last one completes it.
    for (int i = 0; i < 64; i++) send_byte(8'((33 + i) % 95 + 32));
    expect_frame("full64", {"ABCDEFGHIJKLMNOP", "QRSTUVWXYZ[", 8'h5c, "]^_", 8'h60,
                            "abcdefghijklmnop", "qrstuvwxyz{|}~", 8'h20, 8'h21});

    // Backpressure: frame and input both held while the display stalls.
    m_axis_tready = 1'b0;
    send_byte("Z");
    send_byte(8'h0c);
    @(negedge clk);
    check("bp_valid", 512'(m_axis_tvalid), 512'(1));
    held = frame();
    check("bp_data", held, {pad16("Z"), {48{8'h20}}});
    s_axis_tdata  = "Q";
    s_axis_tvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!m_axis_tvalid || s_axis_tready || frame() !== held) bad++;
    end
    check("bp_stable_cycles", 512'(bad), 512'(0));
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 512'(m_axis_tvalid), 512'(0));
    check("bp_release_cleared", frame(), BLANK);
    check("bp_release_sready", 512'(s_axis_tready), 512'(1));
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    send_byte(8'h0c);
    expect_frame("bp_byte_kept", {pad16("Q"), {48{8'h20}}});

    // Reset while a frame is pending discards it.
    m_axis_tready = 1'b0;
    send_byte("A");
    send_byte("B");
    send_byte(8'h0c);
    @(negedge clk);
    check("rs_pending_valid", 512'(m_axis_tvalid), 512'(1));
    resetn = 1'b0;
    @(negedge clk);
    check("rs_valid_drop", 512'(m_axis_tvalid), 512'(0));
    check("rs_sready_low", 512'(s_axis_tready), 512'(0));
    check("rs_cells", frame(), BLANK);
    resetn = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("rs_sready_back", 512'(s_axis_tready), 512'(1));

    // Idle after one printable byte: auto-flush at 17 cycles when enabled.
    send_byte("X");
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (m_axis_tvalid) bad++;
    end
    check("af_quiet_16", 512'(bad), 512'(0));
`ifdef AXIS_TEXT_FRAMER_AUTO_FLUSH_EN
    expect_frame("af_flush", {pad16("X"), {48{8'h20}}});
`else
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_axis_tvalid) bad++;
    end
    check("af_disabled_quiet", 512'(bad), 512'(0));
    send_byte(8'h0c);
    expect_frame("af_manual", {pad16("X"), {48{8'h20}}});
`endif
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_axis_tvalid) bad++;
    end
    check("af_clean_never", 512'(bad), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
